// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave terminating on a word-addressed RAM; one outstanding read and one outstanding write.
// Define AXI_LITE_RAM_SLAVE_WSTRB_EN to add s_wstrb_i byte-strobe writes.
module axi_lite_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_WIDTH = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_arvalid_i,
  output logic        s_aready_o,
  input  logic [31:0] s_araddr_i,
  output logic        s_rvalid_o,
  input  logic        s_rready_i,
  output logic [31:0] s_rdata_o,
  output logic [1:0]  s_rresp_o,
  input  logic        s_awvalid_i,
  output logic        s_awready_o,
  input  logic [31:0] s_awaddr_i,
  input  logic        s_wvalid_i,
  output logic        s_wready_o,
  input  logic [31:0] s_wdata_i,
`ifdef AXI_LITE_RAM_SLAVE_WSTRB_EN
  input  logic [3:0]  s_wstrb_i,
`endif
  output logic        s_bvalid_o,
  input  logic        s_bready_i,
  output logic [1:0]  s_bresp_o
);

  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0]          mem [DEPTH];

  logic                 rd_pend;
  logic [31:0]          ar_addr;
  logic                 aw_got;
  logic                 w_got;
  logic [31:0]          aw_addr;
  logic [31:0]          wdata;
  logic [31:0]          wmask;

  logic [31:0]          rd_off;
  logic [31:0]          wr_off;
  logic                 rd_hit;
  logic                 wr_hit;
  logic [IDX_WIDTH-1:0] rd_idx;
  logic [IDX_WIDTH-1:0] wr_idx;
  logic                 commit;

  assign s_aready_o  = !rd_pend && !s_rvalid_o;
  assign s_awready_o = !aw_got && !s_bvalid_o;
  assign s_wready_o  = !w_got && !s_bvalid_o;
  assign commit      = aw_got && w_got && !s_bvalid_o;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR decode as out of range.
  always_comb begin
    rd_off = ar_addr - BASE_ADDR;
    wr_off = aw_addr - BASE_ADDR;
    rd_hit = rd_off < SPAN;
    wr_hit = wr_off < SPAN;
    rd_idx = rd_off[IDX_WIDTH+1:2];
    wr_idx = wr_off[IDX_WIDTH+1:2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend    <= 1'b0;
      s_rvalid_o <= 1'b0;
      s_rdata_o  <= '0;
      s_rresp_o  <= '0;
    end else begin
      if (s_arvalid_i && s_aready_o) begin
        rd_pend <= 1'b1;
      end
      if (rd_pend) begin
        s_rdata_o  <= rd_hit ? mem[rd_idx] : '0;
        s_rresp_o  <= rd_hit ? 2'b00 : 2'b10;
        s_rvalid_o <= 1'b1;
        rd_pend    <= 1'b0;
      end else if (s_rvalid_o && s_rready_i) begin
        s_rvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      s_bvalid_o <= 1'b0;
      s_bresp_o  <= '0;
    end else begin
      if (s_awvalid_i && s_awready_o) begin
        aw_got <= 1'b1;
      end
      if (s_wvalid_i && s_wready_o) begin
        w_got <= 1'b1;
      end
      if (commit) begin
        s_bresp_o  <= wr_hit ? 2'b00 : 2'b10;
        s_bvalid_o <= 1'b1;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else if (s_bvalid_o && s_bready_i) begin
        s_bvalid_o <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; the flags alone decide whether they are meaningful.
  always_ff @(posedge clk_i) begin
    if (s_arvalid_i && s_aready_o) begin
      ar_addr <= s_araddr_i;
    end
    if (s_awvalid_i && s_awready_o) begin
      aw_addr <= s_awaddr_i;
    end
    if (s_wvalid_i && s_wready_o) begin
      wdata <= s_wdata_i;
`ifdef AXI_LITE_RAM_SLAVE_WSTRB_EN
      wmask <= {{8{s_wstrb_i[3]}}, {8{s_wstrb_i[2]}}, {8{s_wstrb_i[1]}}, {8{s_wstrb_i[0]}}};
`else
      wmask <= '1;
`endif
    end
  end

  // A commit coinciding with reset is dropped; the read path sees pre-write data on a shared edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wr_hit) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wmask) | (wdata & wmask);
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed scoreboard bench for axi_lite_ram_slave; expected R/B responses are queued at issue time.
module tb_axi_lite_ram_slave;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_arvalid_i = 1'b0;
  logic        s_aready_o;
  logic [31:0] s_araddr_i = '0;
  logic        s_rvalid_o;
  logic        s_rready_i = 1'b0;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_awvalid_i = 1'b0;
  logic        s_awready_o;
  logic [31:0] s_awaddr_i = '0;
  logic        s_wvalid_i = 1'b0;
  logic        s_wready_o;
  logic [31:0] s_wdata_i = '0;
`ifdef AXI_LITE_RAM_SLAVE_WSTRB_EN
  logic [3:0]  s_wstrb_i = 4'hF;
`endif
  logic        s_bvalid_o;
  logic        s_bready_i = 1'b0;
  logic [1:0]  s_bresp_o;

  rsp_t        rq[$];
  logic [1:0]  bq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  axi_lite_ram_slave #(
    .BASE_ADDR(BASE),
    .DEPTH(DEPTH),
    .IDX_WIDTH(10)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .s_arvalid_i(s_arvalid_i),
    .s_aready_o(s_aready_o),
    .s_araddr_i(s_araddr_i),
    .s_rvalid_o(s_rvalid_o),
    .s_rready_i(s_rready_i),
    .s_rdata_o(s_rdata_o),
    .s_rresp_o(s_rresp_o),
    .s_awvalid_i(s_awvalid_i),
    .s_awready_o(s_awready_o),
    .s_awaddr_i(s_awaddr_i),
    .s_wvalid_i(s_wvalid_i),
    .s_wready_o(s_wready_o),
    .s_wdata_i(s_wdata_i),
`ifdef AXI_LITE_RAM_SLAVE_WSTRB_EN
    .s_wstrb_i(s_wstrb_i),
`endif
    .s_bvalid_o(s_bvalid_o),
    .s_bready_i(s_bready_i),
    .s_bresp_o(s_bresp_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic take_r(input string tag);
    rsp_t e;
    e = rq.pop_front();
    check({tag, "_rvalid"}, 32'(s_rvalid_o), 32'd1);
    check({tag, "_rdata"}, s_rdata_o, e.data);
    check({tag, "_rresp"}, 32'(s_rresp_o), 32'(e.resp));
  endtask

  task automatic take_b(input string tag);
    logic [1:0] e;
    e = bq.pop_front();
    check({tag, "_bvalid"}, 32'(s_bvalid_o), 32'd1);
    check({tag, "_bresp"}, 32'(s_bresp_o), 32'(e));
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input bit release_b);
    int n;
    bit aw_hs;
    bit w_hs;
    bq.push_back(resp);
    s_awvalid_i = 1'b1;
    s_awaddr_i  = addr;
    s_wvalid_i  = 1'b1;
    s_wdata_i   = data;
    n = 0;
    while ((s_awvalid_i || s_wvalid_i) && n < 20) begin
      aw_hs = s_awvalid_i && s_awready_o;
      w_hs  = s_wvalid_i && s_wready_o;
      step();
      n++;
      if (aw_hs) s_awvalid_i = 1'b0;
      if (w_hs) s_wvalid_i = 1'b0;
    end
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    check({tag, "_b_pre"}, 32'(s_bvalid_o), 32'd0);
    step();
    take_b(tag);
    if (release_b) begin
      s_bready_i = 1'b1;
      step();
      s_bready_i = 1'b0;
      check({tag, "_b_drop"}, 32'(s_bvalid_o), 32'd0);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp);
    int n;
    rq.push_back('{data, resp});
    s_arvalid_i = 1'b1;
    s_araddr_i  = addr;
    n = 0;
    while (!s_aready_o && n < 20) begin
      step();
      n++;
    end
    step();
    s_arvalid_i = 1'b0;
    check({tag, "_r_pre"}, 32'(s_rvalid_o), 32'd0);
    step();
    take_r(tag);
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    check({tag, "_r_drop"}, 32'(s_rvalid_o), 32'd0);
  endtask

  initial begin
    step();
    step();
    check("rst_rvalid", 32'(s_rvalid_o), 32'd0);
    check("rst_bvalid", 32'(s_bvalid_o), 32'd0);
    check("rst_rdata", s_rdata_o, 32'd0);
    check("rst_rresp", 32'(s_rresp_o), 32'd0);
    check("rst_bresp", 32'(s_bresp_o), 32'd0);
    check("rst_aready", 32'(s_aready_o), 32'd1);
    check("rst_awready", 32'(s_awready_o), 32'd1);
    check("rst_wready", 32'(s_wready_o), 32'd1);
    rst_i = 1'b0;
    step();

    do_write("wr10", BASE + 32'h10, 32'hDEAD_BEEF, 2'b00, 1'b1);
    do_read("rd10", BASE + 32'h10, 32'hDEAD_BEEF, 2'b00);

    // W three cycles ahead of AW
    bq.push_back(2'b00);
    s_wvalid_i = 1'b1;
    s_wdata_i  = 32'h1234_5678;
    step();
    s_wvalid_i = 1'b0;
    check("wfirst_wready", 32'(s_wready_o), 32'd0);
    check("wfirst_awready", 32'(s_awready_o), 32'd1);
    step();
    step();
    s_awvalid_i = 1'b1;
    s_awaddr_i  = BASE + 32'h4;
    step();
    s_awvalid_i = 1'b0;
    check("wfirst_b_pre", 32'(s_bvalid_o), 32'd0);
    step();
    take_b("wfirst");
    s_bready_i = 1'b1;
    step();
    s_bready_i = 1'b0;
    do_read("rd04", BASE + 32'h4, 32'h1234_5678, 2'b00);

    do_write("wr00", BASE, 32'h5A5A_0000, 2'b00, 1'b1);
    do_write("wr_oor", BASE + DEPTH * 4, 32'hFFFF_FFFF, 2'b10, 1'b1);
    do_read("rd00", BASE, 32'h5A5A_0000, 2'b00);
    do_read("rd_oor", BASE + DEPTH * 4, 32'h0, 2'b10);
    do_read("rd_below", BASE - 32'h4, 32'h0, 2'b10);

    // read backpressure with a second AR already waiting
    rq.push_back('{32'hDEAD_BEEF, 2'b00});
    s_arvalid_i = 1'b1;
    s_araddr_i  = BASE + 32'h10;
    step();
    s_araddr_i = BASE + 32'h4;
    step();
    for (int i = 0; i < 5; i++) begin
      check("rbp_rvalid", 32'(s_rvalid_o), 32'd1);
      check("rbp_rdata", s_rdata_o, 32'hDEAD_BEEF);
      check("rbp_aready", 32'(s_aready_o), 32'd0);
      step();
    end
    take_r("rbp");
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    check("rbp_drop", 32'(s_rvalid_o), 32'd0);
    check("rbp_aready_after", 32'(s_aready_o), 32'd1);
    rq.push_back('{32'h1234_5678, 2'b00});
    step();
    s_arvalid_i = 1'b0;
    check("rbp2_r_pre", 32'(s_rvalid_o), 32'd0);
    step();
    take_r("rbp2");
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;

    // write backpressure
    do_write("wbp", BASE + 32'h20, 32'h0F0F_0F0F, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("wbp_bvalid", 32'(s_bvalid_o), 32'd1);
      check("wbp_bresp", 32'(s_bresp_o), 32'd0);
      check("wbp_awready", 32'(s_awready_o), 32'd0);
      check("wbp_wready", 32'(s_wready_o), 32'd0);
      step();
    end
    s_bready_i = 1'b1;
    step();
    s_bready_i = 1'b0;
    check("wbp_drop", 32'(s_bvalid_o), 32'd0);
    check("wbp_awready_after", 32'(s_awready_o), 32'd1);
    check("wbp_wready_after", 32'(s_wready_o), 32'd1);
    do_read("rd20", BASE + 32'h20, 32'h0F0F_0F0F, 2'b00);

    // read sample edge coincides with write commit to the same word
    do_write("wr08", BASE + 32'h8, 32'hA, 2'b00, 1'b1);
    rq.push_back('{32'hA, 2'b00});
    bq.push_back(2'b00);
    s_arvalid_i = 1'b1;
    s_araddr_i  = BASE + 32'h8;
    s_awvalid_i = 1'b1;
    s_awaddr_i  = BASE + 32'h8;
    s_wvalid_i  = 1'b1;
    s_wdata_i   = 32'hB;
    step();
    s_arvalid_i = 1'b0;
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    step();
    take_r("same_edge");
    take_b("same_edge");
    s_rready_i = 1'b1;
    s_bready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    s_bready_i = 1'b0;
    do_read("rd08_new", BASE + 32'h8, 32'hB, 2'b00);

    // reset with AW latched and W never sent
    do_write("wr14", BASE + 32'h14, 32'h5555_5555, 2'b00, 1'b1);
    s_awvalid_i = 1'b1;
    s_awaddr_i  = BASE + 32'h14;
    s_wdata_i   = 32'h6666_6666;
    step();
    s_awvalid_i = 1'b0;
    check("mid_awready", 32'(s_awready_o), 32'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rvalid", 32'(s_rvalid_o), 32'd0);
    check("mid_bvalid", 32'(s_bvalid_o), 32'd0);
    check("mid_aready", 32'(s_aready_o), 32'd1);
    check("mid_awready_after", 32'(s_awready_o), 32'd1);
    check("mid_wready", 32'(s_wready_o), 32'd1);
    step();
    check("mid_bvalid_later", 32'(s_bvalid_o), 32'd0);
    do_read("rd14", BASE + 32'h14, 32'h5555_5555, 2'b00);

`ifdef AXI_LITE_RAM_SLAVE_WSTRB_EN
    s_wstrb_i = 4'hF;
    do_write("wr18", BASE + 32'h18, 32'h1122_3344, 2'b00, 1'b1);
    s_wstrb_i = 4'b0101;
    do_write("wr18_strb", BASE + 32'h18, 32'hAABB_CCDD, 2'b00, 1'b1);
    do_read("rd18", BASE + 32'h18, 32'h11BB_33DD, 2'b00);
    s_wstrb_i = 4'b0000;
    do_write("wr18_none", BASE + 32'h18, 32'hFFFF_FFFF, 2'b00, 1'b1);
    do_write("wr_oor_none", BASE + DEPTH * 4, 32'hFFFF_FFFF, 2'b10, 1'b1);
    do_read("rd18_again", BASE + 32'h18, 32'h11BB_33DD, 2'b00);
    s_wstrb_i = 4'hF;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
